tff_array: RTL and testbench

Clocked, multi-channel successor to the ring-oscillator time flip-flop: a bank of `CHANNELS` independent temporal-memory cells. Each cell records the duration of a write pulse as a cycle count and replays that duration as a delayed single-cycle output pulse when read. The block sits in the race-logic datapath wherever time-coded values must be held across phases, with per-channel overflow reporting and an optional complement read mode.

---
 rtl/tff_array.sv | 100 ++++++++++
 tb/tb_tff_array.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/tff_array.sv
// Bank of CHANNELS clocked time flip-flops: each records a we-pulse width as a count and replays it as a delayed out pulse.
// Optional complement replay (N = 2^BITS - t, or 1 after overflow) enabled by defining TFF_ARRAY_COMPLEMENT_EN.
module tff_array #(
    parameter int BITS     = 3,
    parameter int CHANNELS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] we,
    input  logic [CHANNELS-1:0] re,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] carry,
    output logic [CHANNELS-1:0] full
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;
    localparam logic [1:0] S_READ  = 2'd3;

    localparam logic [BITS-1:0] CNT_MAX = '1;
    localparam logic [BITS-1:0] CNT_ONE = BITS'(1);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [1:0]      state;
        logic [BITS-1:0] cnt;
        logic [BITS-1:0] dcnt;
        logic [BITS-1:0] load_n;
        logic            out_r;
        logic            carry_r;
        logic            full_r;

`ifdef TFF_ARRAY_COMPLEMENT_EN
        // Two's complement of t in BITS bits is 2^BITS - t; t is never 0.
        assign load_n = carry_r ? CNT_ONE : (~cnt + CNT_ONE);
`else
        assign load_n = cnt;
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                state   <= S_EMPTY;
                cnt     <= '0;
                dcnt    <= '0;
                out_r   <= 1'b0;
                carry_r <= 1'b0;
                full_r  <= 1'b0;
            end else begin
                out_r <= 1'b0;
                case (state)
                    S_EMPTY: begin
                        if (we[i]) begin
                            state   <= S_WRITE;
                            cnt     <= CNT_ONE;
                            carry_r <= 1'b0;
                        end
                    end
                    S_WRITE: begin
                        if (we[i]) begin
                            if (cnt == CNT_MAX) carry_r <= 1'b1;
                            else                cnt     <= cnt + CNT_ONE;
                        end else begin
                            state  <= S_FULL;
                            full_r <= 1'b1;
                        end
                    end
                    S_FULL: begin
                        if (re[i]) begin
                            state  <= S_READ;
                            dcnt   <= load_n;
                            full_r <= 1'b0;
                        end else if (we[i]) begin
                            state   <= S_WRITE;
                            cnt     <= CNT_ONE;
                            carry_r <= 1'b0;
                            full_r  <= 1'b0;
                        end
                    end
                    default: begin
                        // Pulse fires on the expiring edge; the channel is already EMPTY
                        // during the pulse cycle so the next write can be sampled right after.
                        if (dcnt == CNT_ONE) begin
                            out_r <= 1'b1;
                            state <= S_EMPTY;
                            cnt   <= '0;
                            dcnt  <= '0;
                        end else begin
                            dcnt <= dcnt - CNT_ONE;
                        end
                    end
                endcase
            end
        end

        assign out[i]   = out_r;
        assign carry[i] = carry_r;
        assign full[i]  = full_r;
    end

endmodule

// File: tb/tb_tff_array.sv
// Directed self-checking bench for tff_array with BITS=3, CHANNELS=4.
module tb_tff_array;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] we;
    logic [3:0] re;
    logic [3:0] out;
    logic [3:0] carry;
    logic [3:0] full;

    int n_cmp = 0;
    int n_bad = 0;

    tff_array #(.BITS(3), .CHANNELS(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .re    (re),
        .out   (out),
        .carry (carry),
        .full  (full)
    );

    always #5 clk = ~clk;

    // Replay delay for a stored value t (overflowed writes store 7 with carry set).
    function automatic int n_of(input int t, input bit ovf);
`ifdef TFF_ARRAY_COMPLEMENT_EN
        return ovf ? 1 : 8 - t;
`else
        return t;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic write(input int ch, input int t);
        we[ch] = 1'b1;
        repeat (t) tick();
        we[ch] = 1'b0;
        tick();
    endtask

    // Issue re at edge r (optionally with we held for 'hold' edges) and check the pulse lands at r+n only.
    task automatic check_read(input string tag, input int ch, input int n, input int hold);
        re[ch] = 1'b1;
        if (hold > 0) we[ch] = 1'b1;
        tick();
        re[ch] = 1'b0;
        if (hold <= 1) we[ch] = 1'b0;
        chk({tag, "_full_fall"}, full, 4'b0000);
        for (int k = 1; k < n; k++) begin
            tick();
            if (k + 1 >= hold) we[ch] = 1'b0;
            chk({tag, "_out_early"}, out, 4'b0000);
            chk({tag, "_full_read"}, full, 4'b0000);
        end
        tick();
        chk({tag, "_out_pulse"}, out, 4'b0001 << ch);
        tick();
        chk({tag, "_out_after"}, out, 4'b0000);
    endtask

    initial begin
        logic [3:0] exp_mask;
        rst = 1'b1;
        we  = '0;
        re  = '0;
        tick();
        chk("rst_out",   out,   4'b0000);
        chk("rst_carry", carry, 4'b0000);
        chk("rst_full",  full,  4'b0000);
        rst = 1'b0;
        tick();

        // ch0: store 3, direct read
        we[0] = 1'b1;
        repeat (3) tick();
        chk("ch0_full_during_write", full, 4'b0000);
        we[0] = 1'b0;
        tick();
        chk("ch0_full", full, 4'b0001);
        chk("ch0_carry", carry, 4'b0000);
        check_read("ch0_rd", 0, n_of(3, 1'b0), 0);

        // ch1: 10 high samples saturate at 7 and set carry on the 8th
        we[1] = 1'b1;
        repeat (7) tick();
        chk("ch1_carry_7", carry, 4'b0000);
        tick();
        chk("ch1_carry_8", carry, 4'b0010);
        repeat (2) tick();
        we[1] = 1'b0;
        tick();
        chk("ch1_full", full, 4'b0010);
        check_read("ch1_rd", 1, n_of(7, 1'b1), 0);
        chk("ch1_carry_kept", carry, 4'b0010);
        we[1] = 1'b1;
        tick();
        chk("ch1_carry_clr", carry, 4'b0000);
        we[1] = 1'b0;
        tick();
        chk("ch1_full2", full, 4'b0010);
        check_read("ch1_rd2", 1, n_of(1, 1'b0), 0);

        // ch2: simultaneous we/re in FULL -> read of old value wins, we ignored during READ
        write(2, 4);
        chk("ch2_full", full, 4'b0100);
        check_read("ch2_rw", 2, n_of(4, 1'b0), 3);
        chk("ch2_empty_full", full, 4'b0000);

        // ch2: overwrite 5 with 2
        write(2, 5);
        chk("ch2_full5", full, 4'b0100);
        we[2] = 1'b1;
        tick();
        chk("ch2_ovw_full", full, 4'b0000);
        tick();
        we[2] = 1'b0;
        tick();
        chk("ch2_ovw_full2", full, 4'b0100);
        check_read("ch2_ovw_rd", 2, n_of(2, 1'b0), 0);

        // all channels stored 1..4, read together
        for (int c = 0; c < 4; c++) write(c, c + 1);
        chk("all_full", full, 4'b1111);
        re = 4'b1111;
        tick();
        re = 4'b0000;
        chk("all_full_fall", full, 4'b0000);
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_mask = '0;
            for (int c = 0; c < 4; c++)
                if (n_of(c + 1, 1'b0) == k) exp_mask[c] = 1'b1;
            chk("all_out", out, exp_mask);
        end

        // reset mid-READ on ch0 suppresses the pending pulse
        write(0, 5);
        re[0] = 1'b1;
        tick();
        re[0] = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_out",   out,   4'b0000);
        chk("rst_mid_full",  full,  4'b0000);
        chk("rst_mid_carry", carry, 4'b0000);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rst_mid_no_pulse", out, 4'b0000);
        end
        write(0, 2);
        chk("rst_mid_rewrite", full, 4'b0001);
        check_read("rst_mid_rd", 0, n_of(2, 1'b0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
